button_conditioner: RTL and testbench

- Conditions the raw dock push-buttons S1..S4 before they reach the Bit/register data and load inputs.
- Per channel it provides:
  - a 2-flop synchronizer;
  - polarity normalization;
  - a counter-based debouncer;
  - single-cycle press and release pulses.
- Sits between the board pins and the Bit stage, so every load into a Bit is exactly one clean, clock-aligned event per physical press.

---
 rtl/button_pkg.sv | 15 +
 rtl/button_conditioner_debounce_channel.sv | 87 ++++++++
 rtl/button_conditioner.sv | 40 ++++
 tb/tb_button_conditioner.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared defaults and sizing helper for the push-button conditioning slice.
// Optional auto-repeat is enabled with BUTTON_REPEAT_EN.
package button_pkg;

    localparam int unsigned CLK_HZ                  = 27000000;
    localparam int unsigned DEBOUNCE_MS             = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned REPEAT_DELAY_DEFAULT    = CLK_HZ / 2;
    localparam int unsigned REPEAT_PERIOD_DEFAULT   = CLK_HZ / 10;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchronizer, polarity fix, counter debounce, edge pulses.
// Auto-repeat of btn_press is added when BUTTON_REPEAT_EN is defined.
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned      CW         = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    LAST       = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic             IDLE_LEVEL = (ACTIVE_LOW != 0);

    logic          sync1;
    logic          sync2;
    logic          norm;
    logic          accept;
    logic          rpt_fire;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        norm    = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
        accept  = (norm != btn_level) && (cnt == LAST);
        cnt_nxt = cnt + 1'b1;
        if ((norm == btn_level) || accept) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1       <= IDLE_LEVEL;
            sync2       <= IDLE_LEVEL;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            sync1       <= btn_raw;
            sync2       <= sync1;
            cnt         <= cnt_nxt;
            btn_level   <= accept ? norm : btn_level;
            btn_press   <= (accept && norm) || rpt_fire;
            btn_release <= accept && !norm;
        end
    end

`ifdef BUTTON_REPEAT_EN
    localparam int unsigned   HW          = cnt_width(REPEAT_DELAY);
    localparam logic [HW-1:0] HOLD_FIRE   = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [HW-1:0] hold_cnt;

    // After the first repeat the counter reloads so later repeats come every REPEAT_PERIOD.
    always_comb begin
        rpt_fire = btn_level && !accept && (hold_cnt == HOLD_FIRE);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_cnt <= '0;
        end else if (!btn_level || accept) begin
            hold_cnt <= '0;
        end else if (rpt_fire) begin
            hold_cnt <= HOLD_RELOAD;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    always_comb begin
        rpt_fire = 1'b0;
    end
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BUTTONS raw push-button pins into clean levels and one-cycle pulses.
// Define BUTTON_REPEAT_EN to add auto-repeat press pulses while a button is held.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS     = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
        $error("button_conditioner: invalid DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .Clock       (Clock),
            .Reset_n     (Reset_n),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, active-low pins.
// Repeat expectations follow BUTTON_REPEAT_EN (delay 10, period 5).
module tb_button_conditioner;

    logic       Clock;
    logic       Reset_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int unsigned tests;
    int unsigned fails;

    button_conditioner #(
        .NUM_BUTTONS     (4),
        .DEBOUNCE_CYCLES (4),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // One rising edge, then sit on the falling edge for sampling and driving.
    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge Clock);
            @(negedge Clock);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] prs,
                           input logic [3:0] rel);
        chk({tag, ".level"},   btn_level,   lvl);
        chk({tag, ".press"},   btn_press,   prs);
        chk({tag, ".release"}, btn_release, rel);
    endtask

    initial begin
        logic [3:0] rep_exp;
        tests   = 0;
        fails   = 0;
        Reset_n = 1'b0;
        btn_raw = 4'b0000;

        // Reset state with all pins reading pressed
        tick(2);
        chk_all("reset", 4'b0000, 4'b0000, 4'b0000);

        // Release reset: held buttons accepted on the 6th edge
        Reset_n = 1'b1;
        tick(5);
        chk_all("rst_exit_e5", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk_all("rst_exit_e6", 4'b1111, 4'b1111, 4'b0000);
        tick(1);
        chk_all("rst_exit_e7", 4'b1111, 4'b0000, 4'b0000);

        // Release everything
        btn_raw = 4'b1111;
        tick(5);
        chk_all("rel_all_e5", 4'b1111, 4'b0000, 4'b0000);
        tick(1);
        chk_all("rel_all_e6", 4'b0000, 4'b0000, 4'b1111);
        tick(1);
        chk_all("rel_all_e7", 4'b0000, 4'b0000, 4'b0000);

        // Clean press on channel 0
        btn_raw = 4'b1110;
        tick(5);
        chk_all("press0_e5", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk_all("press0_e6", 4'b0001, 4'b0001, 4'b0000);
        tick(1);
        chk_all("press0_e7", 4'b0001, 4'b0000, 4'b0000);

        // Channel 1 bounces (0,0,0,1 then 0) while channel 0 is released
        btn_raw = 4'b1101;
        tick(3);
        btn_raw = 4'b1111;
        tick(1);
        btn_raw = 4'b1101;
        tick(2);
        chk_all("bounce_e6", 4'b0000, 4'b0000, 4'b0001);
        tick(3);
        chk_all("bounce_e9", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk_all("bounce_e10", 4'b0010, 4'b0010, 4'b0000);
        tick(1);
        chk_all("bounce_e11", 4'b0010, 4'b0000, 4'b0000);

        // Press channels 2,3 while releasing channel 1 on the same edge
        btn_raw = 4'b0011;
        tick(6);
        chk_all("press23_e6", 4'b1100, 4'b1100, 4'b0010);
        tick(1);
        chk_all("press23_e7", 4'b1100, 4'b0000, 4'b0000);

        // Simultaneous release of channels 2 and 3
        btn_raw = 4'b1111;
        tick(5);
        chk_all("rel23_e5", 4'b1100, 4'b0000, 4'b0000);
        tick(1);
        chk_all("rel23_e6", 4'b0000, 4'b0000, 4'b1100);
        tick(1);
        chk_all("rel23_e7", 4'b0000, 4'b0000, 4'b0000);

        // Long hold on channel 0: repeat pulses only when the feature is built in
        btn_raw = 4'b1110;
        tick(6);
        chk_all("hold_accept", 4'b0001, 4'b0001, 4'b0000);
        for (int unsigned k = 1; k <= 29; k++) begin
            tick(1);
`ifdef BUTTON_REPEAT_EN
            rep_exp = (k >= 10 && ((k - 10) % 5) == 0) ? 4'b0001 : 4'b0000;
`else
            rep_exp = 4'b0000;
`endif
            chk($sformatf("hold_k%0d.press", k), btn_press, rep_exp);
            chk($sformatf("hold_k%0d.release", k), btn_release, 4'b0000);
        end

        // Start releasing channel 0, then reset two counts into the debounce
        btn_raw = 4'b1111;
        tick(4);
        chk("midcnt_e4.level", btn_level, 4'b0001);
        chk("midcnt_e4.release", btn_release, 4'b0000);
        Reset_n = 1'b0;
        btn_raw = 4'b1110;
        #1;
        chk_all("async_reset", 4'b0000, 4'b0000, 4'b0000);
        tick(2);
        chk_all("in_reset", 4'b0000, 4'b0000, 4'b0000);

        // Channel 0 held through reset is accepted 6 edges after release
        Reset_n = 1'b1;
        for (int unsigned k = 1; k <= 5; k++) begin
            tick(1);
            chk_all($sformatf("rst2_e%0d", k), 4'b0000, 4'b0000, 4'b0000);
        end
        tick(1);
        chk_all("rst2_e6", 4'b0001, 4'b0001, 4'b0000);
        tick(1);
        chk_all("rst2_e7", 4'b0001, 4'b0000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
